// File: rtl/majority_alarm_pkg.sv
// Shared definitions for the majority alarm tracker.
//   state_e : 2-bit FSM state encoding used by the tracker and its bench.
package majority_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALARM = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/majority_alarm_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, count -> 0
//   clr    : synchronous clear, wins over inc
//   inc    : add one unless already all-ones
//   count  : current count
//   at_max : count is all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    at_max = &count_q;
    count  = count_q;
  end

endmodule

// File: rtl/majority_alarm_tracker.sv
// Tracks streaks of the majority detector output and raises a sticky alarm.
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   en          : 1 advances all state, 0 freezes everything (ack dropped)
//   maj_in      : detector output, 1 = pair or triple present
//   ack         : alarm acknowledge, only meaningful while in ALARM
//   maj_q       : registered maj_in
//   streak      : consecutive enabled cycles with maj_q==1, saturating
//   alarm       : 1 while in ALARM
//   event_count : number of ALARM entries, saturating
//   saturated   : event_count is all-ones
module majority_alarm_tracker
  import majority_alarm_pkg::*;
#(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned THRESH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               maj_in,
  input  logic               ack,
  output logic               maj_q,
  output logic [COUNT_W-1:0] streak,
  output logic               alarm,
  output logic [COUNT_W-1:0] event_count,
  output logic               saturated
);

  localparam logic [COUNT_W-1:0] ThreshW = COUNT_W'(THRESH);

  state_e state_q;
  state_e state_d;
  logic   maj_r;
  logic   streak_full;
  logic   thresh_hit;
  logic   alarm_entry;

  // Input register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj_r <= 1'b0;
    end else if (en) begin
      maj_r <= maj_in;
    end
  end

  sat_counter #(
    .W (COUNT_W)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .clr    (en & ~maj_r),
    .inc    (en & maj_r),
    .count  (streak),
    .at_max (streak_full)
  );

  // A full streak cannot be one below THRESH since THRESH <= all-ones.
  always_comb begin
    thresh_hit = !streak_full && ((streak + COUNT_W'(1)) == ThreshW);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (maj_r) begin
          state_d = (THRESH == 1) ? ALARM : TRACK;
        end
      end
      TRACK: begin
        if (!maj_r) begin
          state_d = IDLE;
        end else if (thresh_hit) begin
          state_d = ALARM;
        end
      end
      ALARM: begin
        if (ack) begin
          state_d = maj_r ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!maj_r) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Entry into ALARM is the only event that bumps the event counter.
  always_comb begin
    alarm_entry = en && (state_d == ALARM) && (state_q != ALARM);
  end

  sat_counter #(
    .W (COUNT_W)
  ) u_events (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .inc    (alarm_entry),
    .count  (event_count),
    .at_max (saturated)
  );

  // Output decode
  always_comb begin
    maj_q = maj_r;
    alarm = (state_q == ALARM);
  end

endmodule
